// File: rtl/soc_system_img_pkg.sv
// rtl/soc_system_img_pkg.sv - shared types and helpers for the image buffer
package soc_system_img_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } img_state_e;

   function automatic int lanes(input int data_w);
      return data_w / 8;
   endfunction

   function automatic bit rd_latency_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

endpackage

// File: rtl/soc_system_img_tdp.sv
// rtl/soc_system_img_tdp.sv - byte-enabled true-dual-port array, read-old-data, registered output
module soc_system_img_tdp
   import soc_system_img_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 10,
   localparam int LANES  = lanes(DATA_W)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_a_we,
   input  logic              i_a_re,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [LANES-1:0]  i_a_be,
   input  logic [DATA_W-1:0] i_a_wdata,
   output logic [DATA_W-1:0] o_a_rdata,
   input  logic              i_b_we,
   input  logic              i_b_re,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [LANES-1:0]  i_b_be,
   input  logic [DATA_W-1:0] i_b_wdata,
   output logic [DATA_W-1:0] o_b_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_a_q;
   logic [DATA_W-1:0] r_b_q;

   // Array contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (i_a_we && i_a_be[l]) r_mem[i_a_addr][8*l +: 8] <= i_a_wdata[8*l +: 8];
         if (i_b_we && i_b_be[l]) r_mem[i_b_addr][8*l +: 8] <= i_b_wdata[8*l +: 8];
      end
   end

   // Output registers load only on a read so the data holds between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a_q <= '0;
         r_b_q <= '0;
      end else begin
         if (i_a_re) r_a_q <= r_mem[i_a_addr];
         if (i_b_re) r_b_q <= r_mem[i_b_addr];
      end
   end

   assign o_a_rdata = r_a_q;
   assign o_b_rdata = r_b_q;

endmodule

// File: rtl/soc_system_img_buf.sv
// rtl/soc_system_img_buf.sv - dual-port image buffer with collision merge and clear engine
module soc_system_img_buf
   import soc_system_img_pkg::*;
#(
   parameter  int DATA_W     = 32,
   parameter  int ADDR_W     = 10,
   parameter  int RD_LATENCY = 1,
   parameter  int INIT_CLEAR = 1,
   localparam int LANES      = lanes(DATA_W)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_chipselect,
   input  logic              a_read,
   input  logic              a_write,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [LANES-1:0]  a_byteenable,
   input  logic [DATA_W-1:0] a_writedata,
   output logic [DATA_W-1:0] a_readdata,
   output logic              a_readdatavalid,
   output logic              a_waitrequest,
   input  logic              b_chipselect,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [LANES-1:0]  b_byteenable,
   input  logic [DATA_W-1:0] b_writedata,
   output logic [DATA_W-1:0] b_readdata,
   output logic              b_readdatavalid,
   output logic              b_waitrequest,
   input  logic              clear_req,
   output logic              clear_busy
);

   if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
      $error("soc_system_img_buf: RD_LATENCY must be 1 or 2");
   end

   img_state_e        r_state;
   img_state_e        w_next;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic              w_last;
   logic              w_a_acc, w_b_acc;
   logic              w_a_wr, w_b_wr, w_a_rd, w_b_rd;
   logic              w_collide;
   logic              w_a_we, w_b_we;
   logic [ADDR_W-1:0] w_a_addr;
   logic [LANES-1:0]  w_a_be;
   logic [DATA_W-1:0] w_a_wdata;
   logic [DATA_W-1:0] w_a_q, w_b_q;
   logic              r_a_v1, r_b_v1;

   assign w_last = (r_clr_cnt == '1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (clear_req) w_next = CLEAR;
         CLEAR:   if (w_last)    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        r_clr_cnt <= '0;
      else if (r_state == CLEAR && !w_last) r_clr_cnt <= r_clr_cnt + 1'b1;
      else                                  r_clr_cnt <= '0;
   end

   assign clear_busy    = (r_state == CLEAR);
   assign a_waitrequest = clear_busy;
   assign b_waitrequest = clear_busy;

   assign w_a_acc   = a_chipselect & (a_read | a_write) & ~clear_busy;
   assign w_b_acc   = b_chipselect & (b_read | b_write) & ~clear_busy;
   assign w_a_wr    = w_a_acc & a_write;
   assign w_b_wr    = w_b_acc & b_write;
   assign w_a_rd    = w_a_acc & a_read & ~a_write;
   assign w_b_rd    = w_b_acc & b_read & ~b_write;
   assign w_collide = w_a_wr & w_b_wr & (a_address == b_address);

   // A colliding B write is folded into port A; A's enabled lanes take priority.
   always_comb begin
      w_a_we    = w_a_wr;
      w_a_addr  = a_address;
      w_a_be    = a_byteenable | (w_collide ? b_byteenable : '0);
      w_a_wdata = '0;
      for (int l = 0; l < LANES; l++) begin
         w_a_wdata[8*l +: 8] = a_byteenable[l] ? a_writedata[8*l +: 8] : b_writedata[8*l +: 8];
      end
      if (clear_busy) begin
         w_a_we    = 1'b1;
         w_a_addr  = r_clr_cnt;
         w_a_be    = '1;
         w_a_wdata = '0;
      end
   end

   assign w_b_we = w_b_wr & ~w_collide;

   soc_system_img_tdp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_tdp (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_a_we    (w_a_we),
      .i_a_re    (w_a_rd),
      .i_a_addr  (w_a_addr),
      .i_a_be    (w_a_be),
      .i_a_wdata (w_a_wdata),
      .o_a_rdata (w_a_q),
      .i_b_we    (w_b_we),
      .i_b_re    (w_b_rd),
      .i_b_addr  (b_address),
      .i_b_be    (b_byteenable),
      .i_b_wdata (b_writedata),
      .o_b_rdata (w_b_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a_v1 <= 1'b0;
         r_b_v1 <= 1'b0;
      end else begin
         r_a_v1 <= w_a_rd;
         r_b_v1 <= w_b_rd;
      end
   end

   if (RD_LATENCY == 2) begin : g_lat2
      logic              r_a_v2, r_b_v2;
      logic [DATA_W-1:0] r_a_d2, r_b_d2;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_a_v2 <= 1'b0;
            r_b_v2 <= 1'b0;
            r_a_d2 <= '0;
            r_b_d2 <= '0;
         end else begin
            r_a_v2 <= r_a_v1;
            r_b_v2 <= r_b_v1;
            if (r_a_v1) r_a_d2 <= w_a_q;
            if (r_b_v1) r_b_d2 <= w_b_q;
         end
      end

      assign a_readdata      = r_a_d2;
      assign b_readdata      = r_b_d2;
      assign a_readdatavalid = r_a_v2;
      assign b_readdatavalid = r_b_v2;
   end else begin : g_lat1
      assign a_readdata      = w_a_q;
      assign b_readdata      = w_b_q;
      assign a_readdatavalid = r_a_v1;
      assign b_readdatavalid = r_b_v1;
   end

endmodule

// File: tb/tb_soc_system_img_buf.sv
// tb/tb_soc_system_img_buf.sv - directed scoreboard bench for the image buffer, latencies 1 and 2
module tb_soc_system_img_buf;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int LN = DW / 8;
   localparam int DEPTH = 2 ** AW;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic a_cs = 0, a_rd = 0, a_wr = 0, b_cs = 0, b_rd = 0, b_wr = 0, clear_req = 0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [LN-1:0] a_be = '0, b_be = '0;
   logic [DW-1:0] a_wd = '0, b_wd = '0;

   logic [DW-1:0] a1_rdata, b1_rdata, a2_rdata, b2_rdata;
   logic a1_rv, b1_rv, a1_wait, b1_wait, busy1;
   logic a2_rv, b2_rv, a2_wait, b2_wait, busy2;

   always #5 clk = ~clk;

   soc_system_img_buf #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1), .INIT_CLEAR(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .a_chipselect(a_cs), .a_read(a_rd), .a_write(a_wr), .a_address(a_addr),
      .a_byteenable(a_be), .a_writedata(a_wd), .a_readdata(a1_rdata),
      .a_readdatavalid(a1_rv), .a_waitrequest(a1_wait),
      .b_chipselect(b_cs), .b_read(b_rd), .b_write(b_wr), .b_address(b_addr),
      .b_byteenable(b_be), .b_writedata(b_wd), .b_readdata(b1_rdata),
      .b_readdatavalid(b1_rv), .b_waitrequest(b1_wait),
      .clear_req(clear_req), .clear_busy(busy1)
   );

   soc_system_img_buf #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(2), .INIT_CLEAR(1)) u_dut2 (
      .clk(clk), .reset_n(reset_n),
      .a_chipselect(a_cs), .a_read(a_rd), .a_write(a_wr), .a_address(a_addr),
      .a_byteenable(a_be), .a_writedata(a_wd), .a_readdata(a2_rdata),
      .a_readdatavalid(a2_rv), .a_waitrequest(a2_wait),
      .b_chipselect(b_cs), .b_read(b_rd), .b_write(b_wr), .b_address(b_addr),
      .b_byteenable(b_be), .b_writedata(b_wd), .b_readdata(b2_rdata),
      .b_readdatavalid(b2_rv), .b_waitrequest(b2_wait),
      .clear_req(clear_req), .clear_busy(busy2)
   );

   int cyc = 0;
   always @(posedge clk) cyc++;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [DW-1:0] d;
      int            due;
      bit            any0;
   } exp_t;

   exp_t q1a[$], q1b[$], q2a[$], q2b[$];
   logic [DW-1:0] model [DEPTH];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input exp_t e, input logic [DW-1:0] obs);
      checks++;
      assert ((obs === e.d) || (e.any0 && obs === '0)) else begin
         errors++;
         $error("FAIL %s_data observed=%h expected=%h", tag, obs, e.d);
      end
      chk({tag, "_cycle"}, DW'(cyc), DW'(e.due));
   endtask

   always @(negedge clk) begin
      if (a1_rv) begin
         chk("a1_valid_expected", DW'(q1a.size() > 0), 1);
         if (q1a.size() > 0) chk_rd("a1_read", q1a.pop_front(), a1_rdata);
      end
      if (b1_rv) begin
         chk("b1_valid_expected", DW'(q1b.size() > 0), 1);
         if (q1b.size() > 0) chk_rd("b1_read", q1b.pop_front(), b1_rdata);
      end
      if (a2_rv) begin
         chk("a2_valid_expected", DW'(q2a.size() > 0), 1);
         if (q2a.size() > 0) chk_rd("a2_read", q2a.pop_front(), a2_rdata);
      end
      if (b2_rv) begin
         chk("b2_valid_expected", DW'(q2b.size() > 0), 1);
         if (q2b.size() > 0) chk_rd("b2_read", q2b.pop_front(), b2_rdata);
      end
   end

   function automatic void mwrite(input logic [AW-1:0] ad, input logic [LN-1:0] be, input logic [DW-1:0] d);
      for (int l = 0; l < LN; l++)
         if (be[l]) model[ad][8*l +: 8] = d[8*l +: 8];
   endfunction

   // One bus cycle on both ports; reads see the model before this cycle's writes.
   task automatic go(input bit ar, input bit aw, input logic [AW-1:0] aad, input logic [LN-1:0] abe,
                     input logic [DW-1:0] awd, input bit br, input bit bw, input logic [AW-1:0] bad,
                     input logic [LN-1:0] bbe, input logic [DW-1:0] bwd, input bit clr, input bit any0);
      a_cs = ar | aw; a_rd = ar; a_wr = aw; a_addr = aad; a_be = abe; a_wd = awd;
      b_cs = br | bw; b_rd = br; b_wr = bw; b_addr = bad; b_be = bbe; b_wd = bwd;
      clear_req = clr;
      if (ar && !aw) begin
         q1a.push_back('{model[aad], cyc + 1, any0});
         q2a.push_back('{model[aad], cyc + 2, any0});
      end
      if (br && !bw) begin
         q1b.push_back('{model[bad], cyc + 1, any0});
         q2b.push_back('{model[bad], cyc + 2, any0});
      end
      if (bw) mwrite(bad, bbe, bwd);
      if (aw) mwrite(aad, abe, awd);
      @(posedge clk); #1;
      a_cs = 0; a_rd = 0; a_wr = 0; b_cs = 0; b_rd = 0; b_wr = 0; clear_req = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wr_a(input logic [AW-1:0] ad, input logic [LN-1:0] be, input logic [DW-1:0] d);
      go(0, 1, ad, be, d, 0, 0, '0, '0, '0, 0, 0);
   endtask

   // Counts cycles with waitrequest high; optionally pulses clear_req at iteration pulse_at.
   task automatic count_busy(output int n, input int pulse_at);
      n = 0;
      while (a1_wait && n < 100) begin
         if (n == pulse_at) clear_req = 1;
         n++;
         @(posedge clk); #1;
         clear_req = 0;
      end
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   int nb;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values
      idle(3);
      chk("rst_a1_rdata", a1_rdata, 0);
      chk("rst_b2_rdata", b2_rdata, 0);
      chk("rst_a1_rv", DW'(a1_rv), 0);
      chk("rst_b2_rv", DW'(b2_rv), 0);
      chk("rst_busy1", DW'(busy1), 1);
      chk("rst_a2_wait", DW'(a2_wait), 1);
      chk("rst_b1_wait", DW'(b1_wait), 1);

      // Initial clear sweep on reset release
      reset_n = 1;
      count_busy(nb, -1);
      chk("init_sweep_cycles", DW'(nb), 16);
      chk("init_sweep_busy2", DW'(busy2), 0);
      chk("init_sweep_b2_wait", DW'(b2_wait), 0);
      for (int i = 0; i < DEPTH; i++)
         go(1, 0, AW'(i), '0, '0, 1, 0, AW'(DEPTH - 1 - i), '0, '0, 0, 0);

      // Byte-enabled partial write
      wr_a(5, 4'hF, 32'h1122_3344);
      wr_a(5, 4'b0101, 32'hDEAD_BEEF);
      go(0, 0, '0, '0, '0, 1, 0, 5, '0, '0, 0, 0);
      chk("model_partial", model[5], 32'h11AD_33EF);

      // Same-address write collision
      go(0, 1, 7, 4'b0011, 32'hAAAA_AAAA, 0, 1, 7, 4'b1111, 32'hBBBB_BBBB, 0, 0);
      go(1, 0, 7, '0, '0, 0, 0, '0, '0, '0, 0, 0);
      chk("model_collide", model[7], 32'hBBBB_AAAA);

      // Back-to-back reads on both ports
      for (int i = 0; i < 8; i++) wr_a(AW'(i), 4'hF, 32'h0101_0101 * (i + 1) + 32'h10);
      for (int i = 0; i < 8; i++) go(1, 0, AW'(i), '0, '0, 1, 0, AW'(i), '0, '0, 0, 0);

      // Read+write on A drops the read; B reading the same word sees old data
      go(1, 1, 3, 4'hF, 32'hA5A5_A5A5, 1, 0, 3, '0, '0, 0, 0);
      go(1, 0, 3, '0, '0, 1, 0, 3, '0, '0, 0, 0);

      // clear_req while port B streams reads; second pulse mid-sweep is ignored
      for (int i = 8; i < 16; i++) wr_a(AW'(i), 4'hF, 32'hC0DE_0000 + i);
      go(0, 0, '0, '0, '0, 1, 0, 8, '0, '0, 0, 0);
      go(0, 0, '0, '0, '0, 1, 0, 9, '0, '0, 0, 0);
      go(0, 0, '0, '0, '0, 1, 0, 10, '0, '0, 1, 1);
      chk("clr_wait_rise_b1", DW'(b1_wait), 1);
      chk("clr_wait_rise_b2", DW'(b2_wait), 1);
      count_busy(nb, 5);
      chk("clr_sweep_cycles", DW'(nb), 16);
      chk("clr_busy2_done", DW'(busy2), 0);
      for (int i = 0; i < 4; i++) go(1, 0, AW'(2 * i + 1), '0, '0, 1, 0, AW'(15 - i), '0, '0, 0, 0);

      // Reset mid-sweep at counter 9 aborts, then restarts from 0
      wr_a(3, 4'hF, 32'h3333_3333);
      wr_a(15, 4'hF, 32'hFFFF_0000);
      go(1, 0, 15, '0, '0, 0, 0, '0, '0, '0, 0, 0);
      go(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 0);
      idle(9);
      chk("pre_rst_a1_rdata", a1_rdata, 32'hFFFF_0000);
      reset_n = 0;
      #1;
      chk("mid_rst_a1_rdata", a1_rdata, 0);
      chk("mid_rst_a2_rdata", a2_rdata, 0);
      chk("mid_rst_a2_rv", DW'(a2_rv), 0);
      chk("mid_rst_busy1", DW'(busy1), 1);
      @(posedge clk); #1;
      reset_n = 1;
      count_busy(nb, -1);
      chk("restart_sweep_cycles", DW'(nb), 16);
      go(1, 0, 15, '0, '0, 1, 0, 3, '0, '0, 0, 0);
      go(1, 0, 0, '0, '0, 1, 0, 9, '0, '0, 0, 0);

      idle(4);
      chk("q1a_drained", DW'(q1a.size()), 0);
      chk("q1b_drained", DW'(q1b.size()), 0);
      chk("q2a_drained", DW'(q2a.size()), 0);
      chk("q2b_drained", DW'(q2b.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
